// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader.
// Holds the loader state type and the HALT_WORD terminator.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first, pulses word_valid
// for one cycle after the 4th byte. Ports: clk, rst, clr, accept,
// data -> word_valid, word.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && (cnt == 2'd3);
      if (accept) begin
        word <= {word[23:0], data};
        // 2-bit counter wraps 3 -> 0, realigning on the next word
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams program bytes into instruction RAM and holds the CPU in reset
// until the halt word is written.
// Ports: clk, rst, start, in_valid/in_data/in_ready (byte stream),
// mem_we/mem_addr/mem_wdata (RAM write), cpu_rst, done, error,
// word_count, checksum. Macro PROG_LOADER_CHECKSUM_EN enables the
// running checksum; otherwise checksum is tied to 0.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wcnt;
  logic              wv;
  logic [31:0]       word;
  logic              arm;
  logic              is_halt;
  logic              accept;

  assign arm     = start && (state != LOAD);
  assign is_halt = (word == HALT_WORD);
  // drop ready during the halt write so no byte is taken after it
  assign in_ready = (state == LOAD) && !(wv && is_halt);
  assign accept   = in_valid && in_ready;

  prog_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (arm),
    .accept     (accept),
    .data       (in_data),
    .word_valid (wv),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      wcnt  <= '0;
    end else if (arm) begin
      state <= LOAD;
      addr  <= '0;
      wcnt  <= '0;
    end else if (state == LOAD && wv) begin
      wcnt <= wcnt + 1'b1;
      if (is_halt)
        state <= DONE;
      else if (addr == LAST)
        state <= ERR;
      else
        addr <= addr + 1'b1;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (arm)
      sum <= '0;
    else if (wv)
      sum <= sum + word;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

  assign mem_we     = wv;
  assign mem_addr   = addr;
  assign mem_wdata  = word;
  assign word_count = wcnt;
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  // start out of DONE reasserts CPU reset in the same cycle
  assign cpu_rst    = (state != DONE) || start;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven load sequence plus
// hand-written multi-cycle sequences on a default and a 4-word instance.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, mem_we, cpu_rst, done, error;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [9:0]  word_count;

  logic        in_ready2, mem_we2, cpu_rst2, done2, error2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2, checksum2;
  logic [2:0]  word_count2;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM = 32'h2008_0004;
`else
  localparam logic [31:0] EXP_SUM = 32'h0;
`endif

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error),
    .word_count(word_count), .checksum(checksum)
  );

  prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_rst(cpu_rst2), .done(done2), .error(error2),
    .word_count(word_count2), .checksum(checksum2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // write log, filled by the monitor only
  logic [8:0]  wa [64];
  logic [31:0] wd [64];
  int          nw = 0;
  int          dbl = 0;
  logic        prev_we = 1'b0;
  logic [1:0]  w2a [16];
  int          n2 = 0;

  always @(negedge clk) begin
    if (mem_we && nw < 64) begin
      wa[nw] = mem_addr;
      wd[nw] = mem_wdata;
    end
    if (mem_we) nw++;
    if (mem_we && prev_we) dbl++;
    prev_we = mem_we;
    if (mem_we2 && n2 < 16) w2a[n2] = mem_addr2;
    if (mem_we2) n2++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0] bq [16];
  int         nb;

  task automatic load_034();
    bq[0] = 8'h20; bq[1] = 8'h08; bq[2] = 8'h00; bq[3] = 8'h05;
    bq[4] = 8'hFF; bq[5] = 8'hFF; bq[6] = 8'hFF; bq[7] = 8'hFF;
    nb = 8;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input bit toggle);
    for (int i = 0; i < nb; i++) begin
      int   guard;
      logic acc;
      guard = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data = bq[i];
      while (!acc && guard < 8) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      tests++;
      if (!acc) begin
        fails++;
        $display("FAIL feed byte %0d: in_ready got 0 expected 1", i);
      end
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [8:0]  a;
    logic [31:0] wdat;
    logic        rdy;
    logic        dn;
    logic        cr;
    logic [9:0]  wc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int base;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 9'd0, 32'h0,        1'b0, 1'b0, 1'b1, 10'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h20, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h08, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h05, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 9'd0, 32'h20080005, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 9'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 10'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 9'd0, 32'h0,        1'b0, 1'b1, 1'b0, 10'd2};

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst cpu_rst", cpu_rst, 1'b1);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst error", error, 1'b0);
    chk("rst mem_addr", mem_addr, 9'd0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst word_count", word_count, 10'd0);
    chk("rst checksum", checksum, 32'h0);
    @(posedge clk); #1;

    // basic load, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st;
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].a);
        chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].wdat);
      end
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d cpu_rst", i), cpu_rst, tbl[i].cr);
      chk($sformatf("vec%0d word_count", i), word_count, tbl[i].wc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("load checksum", checksum, EXP_SUM);
    @(posedge clk); #1;

    // restart from DONE
    start = 1'b1;
    @(negedge clk);
    chk("restart cpu_rst same cycle", cpu_rst, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart word_count", word_count, 10'd0);
    chk("restart done", done, 1'b0);
    chk("restart in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    base = nw;
    bq[0] = 8'h01; bq[1] = 8'h02; bq[2] = 8'h03; bq[3] = 8'h04;
    nb = 4;
    feed(1'b0);
    wait_cycles(2);
    chk("restart nwrites", nw - base, 1);
    chk("restart addr", wa[base], 9'd0);
    chk("restart data", wd[base], 32'h01020304);

    // valid toggled every cycle
    do_reset();
    pulse_start();
    base = nw;
    dbl = 0;
    load_034();
    feed(1'b1);
    begin
      int g;
      g = 0;
      while (!done && g < 10) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("toggle done", done, 1'b1);
    chk("toggle cpu_rst", cpu_rst, 1'b0);
    chk("toggle nwrites", nw - base, 2);
    chk("toggle addr0", wa[base], 9'd0);
    chk("toggle data0", wd[base], 32'h20080005);
    chk("toggle addr1", wa[base+1], 9'd1);
    chk("toggle data1", wd[base+1], 32'hFFFFFFFF);
    chk("toggle we width", dbl, 0);
    chk("toggle word_count", word_count, 10'd2);
    chk("toggle checksum", checksum, EXP_SUM);

    // RAM overflow on the 4-word instance
    do_reset();
    pulse_start();
    base = n2;
    for (int i = 0; i < 16; i++) bq[i] = 8'h00;
    nb = 16;
    feed(1'b0);
    wait_cycles(4);
    chk("ovf error", error2, 1'b1);
    chk("ovf cpu_rst", cpu_rst2, 1'b1);
    chk("ovf in_ready", in_ready2, 1'b0);
    chk("ovf done", done2, 1'b0);
    chk("ovf nwrites", n2 - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf addr%0d", i), w2a[base+i], i[1:0]);
    chk("ovf word_count", word_count2, 3'd4);
    pulse_start();
    @(negedge clk);
    chk("ovf restart error", error2, 1'b0);
    chk("ovf restart in_ready", in_ready2, 1'b1);
    @(posedge clk); #1;

    // reset in the middle of a word
    do_reset();
    pulse_start();
    bq[0] = 8'hAA; bq[1] = 8'hBB;
    nb = 2;
    feed(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst cpu_rst", cpu_rst, 1'b1);
    chk("midrst in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start();
    base = nw;
    bq[0] = 8'h11; bq[1] = 8'h22; bq[2] = 8'h33; bq[3] = 8'h44;
    nb = 4;
    feed(1'b0);
    wait_cycles(2);
    chk("midrst nwrites", nw - base, 1);
    chk("midrst addr", wa[base], 9'd0);
    chk("midrst data", wd[base], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
